// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared types and constants for the score overlay
package score_pkg;

  // Packed 3-digit BCD: [2] hundreds, [1] tens, [0] units, so it concatenates as {h, t, u}.
  typedef logic [2:0][3:0] bcd3_t;

  localparam int          ROM_AW          = 19;
  localparam logic [23:0] SPR_TRANSPARENT = 24'hFFFFFF;

endpackage

// File: rtl/bcd_counter3.sv
// rtl/bcd_counter3.sv - saturating 3-digit BCD score counter with clear
module bcd_counter3
  import score_pkg::*;
(
  input  logic  clk,
  input  logic  resetn,
  input  logic  inc,
  input  logic  clr,
  output bcd3_t bcd
);

  bcd3_t cnt_q, cnt_d;
  logic  carry;

  always_comb begin
    cnt_d = cnt_q;
    carry = 1'b1;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != 12'h999)) begin
      // Ripple the +1 from units upward; stops at the first digit that does not wrap.
      for (int i = 0; i < 3; i++) begin
        if (carry) begin
          if (cnt_q[i] == 4'd9) begin
            cnt_d[i] = 4'd0;
          end else begin
            cnt_d[i] = cnt_q[i] + 4'd1;
            carry    = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign bcd = cnt_q;

endmodule

// File: rtl/score_digit_renderer.sv
// rtl/score_digit_renderer.sv - 3-digit score overlay: snapshot, sprite addressing, 2-cycle colour pipe
module score_digit_renderer
  import score_pkg::*;
#(
  parameter int X0    = 16,
  parameter int Y0    = 16,
  parameter int SPR_W = 32,
  parameter int SPR_H = 32
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              frame_start,
  input  logic              score_inc,
  input  logic              score_clr,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [3:0]        digit_sel,
  input  logic [23:0]       rom_rgb,
  output logic              score_on,
  output logic [23:0]       pixel_rgb,
  output logic [11:0]       score_bcd
);

  localparam int SW = $clog2(SPR_W);
  localparam int SH = $clog2(SPR_H);

  localparam logic [10:0] X0_L = 11'(X0);
  localparam logic [10:0] X1_L = 11'(X0 + SPR_W);
  localparam logic [10:0] X2_L = 11'(X0 + 2 * SPR_W);
  localparam logic [10:0] X3_L = 11'(X0 + 3 * SPR_W);
  localparam logic [10:0] Y0_L = 11'(Y0);
  localparam logic [10:0] Y1_L = 11'(Y0 + SPR_H);

  bcd3_t             live_bcd;
  bcd3_t             disp_q, disp_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic [3:0]        digit_sel_q, digit_sel_d;
  logic              hit_d1_q, hit_d1_d;
  logic              hit_d2_q, hit_d2_d;

  logic [10:0] x11, y11, base_x;
  logic [1:0]  slot;
  logic        in_slot, blank;
  logic [3:0]  digit;
  logic [SW-1:0] local_x;
  logic [SH-1:0] local_y;

  bcd_counter3 u_counter (
    .clk    (Clk),
    .resetn (Reset_n),
    .inc    (score_inc),
    .clr    (score_clr),
    .bcd    (live_bcd)
  );

  assign x11 = {1'b0, DrawX};
  assign y11 = {1'b0, DrawY};

  always_comb begin
    slot    = 2'd0;
    base_x  = X0_L;
    in_slot = (y11 >= Y0_L) && (y11 < Y1_L) && (x11 >= X0_L) && (x11 < X3_L);
    if (x11 >= X2_L) begin
      slot   = 2'd2;
      base_x = X2_L;
    end else if (x11 >= X1_L) begin
      slot   = 2'd1;
      base_x = X1_L;
    end
    local_x = SW'(x11 - base_x);
    local_y = SH'(y11 - Y0_L);
    // Leading-zero blanking looks at the snapshot, never the live count.
    case (slot)
      2'd0:    begin digit = disp_q[2]; blank = (disp_q[2] == 4'd0); end
      2'd1:    begin digit = disp_q[1]; blank = (disp_q[2] == 4'd0) && (disp_q[1] == 4'd0); end
      default: begin digit = disp_q[0]; blank = 1'b0; end
    endcase
  end

  always_comb begin
    disp_d      = frame_start ? live_bcd : disp_q;
    rom_addr_d  = in_slot ? ROM_AW'({local_y, local_x}) : '0;
    digit_sel_d = in_slot ? digit : 4'd0;
    hit_d1_d    = in_slot && !blank;
    hit_d2_d    = hit_d1_q;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      disp_q      <= '0;
      rom_addr_q  <= '0;
      digit_sel_q <= '0;
      hit_d1_q    <= 1'b0;
      hit_d2_q    <= 1'b0;
    end else begin
      disp_q      <= disp_d;
      rom_addr_q  <= rom_addr_d;
      digit_sel_q <= digit_sel_d;
      hit_d1_q    <= hit_d1_d;
      hit_d2_q    <= hit_d2_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign digit_sel = digit_sel_q;
  assign score_on  = hit_d2_q && (rom_rgb != SPR_TRANSPARENT);
  assign pixel_rgb = score_on ? rom_rgb : 24'h000000;
  assign score_bcd = live_bcd;

endmodule

// File: tb/tb_score_digit_renderer.sv
// tb/tb_score_digit_renderer.sv - directed self-checking bench for score_digit_renderer
module tb_score_digit_renderer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  draw_x, draw_y;
  logic        frame_start, score_inc, score_clr;
  logic [18:0] rom_addr;
  logic [3:0]  digit_sel;
  logic [23:0] rom_rgb;
  logic        score_on;
  logic [23:0] pixel_rgb;
  logic [11:0] score_bcd;

  int n_checks = 0;
  int n_fail   = 0;

  score_digit_renderer dut (
    .Clk         (clk),
    .Reset_n     (reset_n),
    .DrawX       (draw_x),
    .DrawY       (draw_y),
    .frame_start (frame_start),
    .score_inc   (score_inc),
    .score_clr   (score_clr),
    .rom_addr    (rom_addr),
    .digit_sel   (digit_sel),
    .rom_rgb     (rom_rgb),
    .score_on    (score_on),
    .pixel_rgb   (pixel_rgb),
    .score_bcd   (score_bcd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_inc(input int n);
    score_inc = 1'b1;
    repeat (n) tick();
    score_inc = 1'b0;
  endtask

  task automatic do_clr();
    score_clr = 1'b1;
    tick();
    score_clr = 1'b0;
  endtask

  task automatic do_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic set_pixel(input int x, input int y);
    draw_x = 10'(x);
    draw_y = 10'(y);
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    draw_x = 10'd80; draw_y = 10'd20; rom_rgb = 24'h000000;
    tick(); tick();
    n_checks++; if (score_bcd !== 12'h000) begin n_fail++; $display("FAIL reset_score got %h exp 000", score_bcd); end
    n_checks++; if (rom_addr !== 19'd0) begin n_fail++; $display("FAIL reset_addr got %0d exp 0", rom_addr); end
    n_checks++; if (digit_sel !== 4'd0) begin n_fail++; $display("FAIL reset_digit got %0d exp 0", digit_sel); end
    n_checks++; if (score_on !== 1'b0 || pixel_rgb !== 24'h0) begin n_fail++; $display("FAIL reset_on got %b/%h exp 0/000000", score_on, pixel_rgb); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_count12();
    do_inc(12);
    n_checks++; if (score_bcd !== 12'h012) begin n_fail++; $display("FAIL count12 got %h exp 012", score_bcd); end
    rom_rgb = 24'h000000;
    set_pixel(20, 20);
    n_checks++; if (score_on !== 1'b0) begin n_fail++; $display("FAIL no_snap_hundreds got %b exp 0", score_on); end
    set_pixel(60, 20);
    n_checks++; if (score_on !== 1'b0) begin n_fail++; $display("FAIL no_snap_tens got %b exp 0", score_on); end
    set_pixel(80, 20);
    n_checks++; if (score_on !== 1'b1 || digit_sel !== 4'd0) begin n_fail++; $display("FAIL no_snap_units got %b/%0d exp 1/0", score_on, digit_sel); end
  endtask

  task automatic test_saturate();
    do_clr();
    do_inc(999);
    n_checks++; if (score_bcd !== 12'h999) begin n_fail++; $display("FAIL reach999 got %h exp 999", score_bcd); end
    do_inc(1);
    n_checks++; if (score_bcd !== 12'h999) begin n_fail++; $display("FAIL saturate got %h exp 999", score_bcd); end
    score_inc = 1'b1; score_clr = 1'b1;
    tick();
    score_inc = 1'b0; score_clr = 1'b0;
    n_checks++; if (score_bcd !== 12'h000) begin n_fail++; $display("FAIL clr_priority got %h exp 000", score_bcd); end
  endtask

  task automatic test_units_only();
    do_inc(7);
    do_frame();
    rom_rgb = 24'h000000;
    for (int x = 16; x < 112; x += 8) begin
      set_pixel(x, 16);
      n_checks++;
      if (score_on !== (x >= 80)) begin n_fail++; $display("FAIL sweep_x%0d got %b exp %b", x, score_on, (x >= 80)); end
    end
    draw_x = 10'd80; draw_y = 10'd16;
    tick();
    n_checks++; if (rom_addr !== 19'd0 || digit_sel !== 4'd7) begin n_fail++; $display("FAIL units_n1 got %0d/%0d exp 0/7", rom_addr, digit_sel); end
    set_pixel(111, 47);
    n_checks++; if (score_on !== 1'b1 || rom_addr !== 19'd1023) begin n_fail++; $display("FAIL corner got %b/%0d exp 1/1023", score_on, rom_addr); end
    set_pixel(112, 20);
    n_checks++; if (score_on !== 1'b0 || rom_addr !== 19'd0 || digit_sel !== 4'd0) begin n_fail++; $display("FAIL right_edge got %b/%0d/%0d exp 0/0/0", score_on, rom_addr, digit_sel); end
    set_pixel(90, 48);
    n_checks++; if (score_on !== 1'b0 || rom_addr !== 19'd0) begin n_fail++; $display("FAIL bottom_edge got %b/%0d exp 0/0", score_on, rom_addr); end
    set_pixel(90, 15);
    n_checks++; if (score_on !== 1'b0) begin n_fail++; $display("FAIL top_edge got %b exp 0", score_on); end
  endtask

  task automatic test_addr();
    do_clr();
    do_inc(305);
    do_frame();
    rom_rgb = 24'h000000;
    draw_x = 10'd50; draw_y = 10'd20;
    tick();
    n_checks++; if (rom_addr !== 19'd130 || digit_sel !== 4'd0) begin n_fail++; $display("FAIL addr130 got %0d/%0d exp 130/0", rom_addr, digit_sel); end
    tick();
    n_checks++; if (score_on !== 1'b1 || pixel_rgb !== 24'h000000) begin n_fail++; $display("FAIL black_px got %b/%h exp 1/000000", score_on, pixel_rgb); end
    rom_rgb = 24'hFFFFFF;
    #1;
    n_checks++; if (score_on !== 1'b0 || pixel_rgb !== 24'h000000) begin n_fail++; $display("FAIL transparent got %b/%h exp 0/000000", score_on, pixel_rgb); end
    rom_rgb = 24'h123456;
    #1;
    n_checks++; if (score_on !== 1'b1 || pixel_rgb !== 24'h123456) begin n_fail++; $display("FAIL colour got %b/%h exp 1/123456", score_on, pixel_rgb); end
    set_pixel(47, 47);
    n_checks++; if (rom_addr !== 19'd1023 || digit_sel !== 4'd3) begin n_fail++; $display("FAIL hundreds got %0d/%0d exp 1023/3", rom_addr, digit_sel); end
  endtask

  task automatic test_snapshot();
    do_clr();
    do_inc(10);
    do_frame();
    do_inc(1);
    n_checks++; if (score_bcd !== 12'h011) begin n_fail++; $display("FAIL live011 got %h exp 011", score_bcd); end
    set_pixel(60, 30);
    n_checks++; if (digit_sel !== 4'd1) begin n_fail++; $display("FAIL snap_tens got %0d exp 1", digit_sel); end
    set_pixel(90, 30);
    n_checks++; if (digit_sel !== 4'd0) begin n_fail++; $display("FAIL snap_units got %0d exp 0", digit_sel); end
    frame_start = 1'b1; score_inc = 1'b1;
    tick();
    frame_start = 1'b0; score_inc = 1'b0;
    n_checks++; if (score_bcd !== 12'h012) begin n_fail++; $display("FAIL live012 got %h exp 012", score_bcd); end
    set_pixel(90, 30);
    n_checks++; if (digit_sel !== 4'd1) begin n_fail++; $display("FAIL snap_old got %0d exp 1", digit_sel); end
    do_frame();
    set_pixel(90, 30);
    n_checks++; if (digit_sel !== 4'd2) begin n_fail++; $display("FAIL snap_new got %0d exp 2", digit_sel); end
  endtask

  task automatic test_reset_mid();
    rom_rgb = 24'h000000;
    set_pixel(60, 30);
    n_checks++; if (score_on !== 1'b1) begin n_fail++; $display("FAIL pre_reset got %b exp 1", score_on); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_checks++; if (score_on !== 1'b0 || score_bcd !== 12'h000 || rom_addr !== 19'd0) begin n_fail++; $display("FAIL mid_reset got %b/%h/%0d exp 0/000/0", score_on, score_bcd, rom_addr); end
    do_frame();
    set_pixel(60, 30);
    n_checks++; if (score_on !== 1'b0) begin n_fail++; $display("FAIL post_reset_tens got %b exp 0", score_on); end
    set_pixel(90, 30);
    n_checks++; if (score_on !== 1'b1 || digit_sel !== 4'd0) begin n_fail++; $display("FAIL post_reset_units got %b/%0d exp 1/0", score_on, digit_sel); end
  endtask

  initial begin
    reset_n = 1'b0; draw_x = '0; draw_y = '0; rom_rgb = '0;
    frame_start = 1'b0; score_inc = 1'b0; score_clr = 1'b0;
    test_reset();
    test_count12();
    test_saturate();
    test_units_only();
    test_addr();
    test_snapshot();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
